// File: rtl/angle_quadrant_reducer_pkg.sv
// -----------------------------------------------------------------------------
// angle_quadrant_reducer_pkg
// Shared constants, quadrant codes, FSM encoding and the quadrant-fold helper
// used by the angle quadrant reducer and its mod-360 iteration datapath.
// Also supplies a default for the shared `DATA_WIDTH define when the wider
// codebase has not already provided one.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package angle_quadrant_reducer_pkg;

    // Angle constants in degrees, 9 bits wide so 360 fits.
    localparam logic [8:0] DEG_FULL_TURN = 9'd360;
    localparam logic [8:0] DEG_HALF_TURN = 9'd180;
    localparam logic [8:0] DEG_RIGHT     = 9'd90;
    localparam logic [8:0] DEG_3_RIGHT   = 9'd270;

    // Quadrant codes.
    localparam logic [1:0] QUAD_I   = 2'd0;
    localparam logic [1:0] QUAD_II  = 2'd1;
    localparam logic [1:0] QUAD_III = 2'd2;
    localparam logic [1:0] QUAD_IV  = 2'd3;

    // Top-level FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_FOLD   = 2'd2,
        ST_DONE   = 2'd3
    } aqr_state_e;

    // Result of folding a 0..359 angle into quadrant + reference angle.
    typedef struct packed {
        logic [1:0] quad;
        logic [6:0] ref_angle;
    } fold_result_t;

    // Map an angle in 0..359 onto its quadrant and 0..90 reference angle.
    function automatic fold_result_t fold_quadrant(input logic [8:0] rem);
        fold_result_t res;
        if (rem < DEG_RIGHT) begin
            res.quad      = QUAD_I;
            res.ref_angle = 7'(rem);
        end else if (rem < DEG_HALF_TURN) begin
            res.quad      = QUAD_II;
            res.ref_angle = 7'(DEG_HALF_TURN - rem);
        end else if (rem < DEG_3_RIGHT) begin
            res.quad      = QUAD_III;
            res.ref_angle = 7'(rem - DEG_HALF_TURN);
        end else begin
            res.quad      = QUAD_IV;
            res.ref_angle = 7'(DEG_FULL_TURN - rem);
        end
        return res;
    endfunction

endpackage

// File: rtl/angle_mod360_iter.sv
// -----------------------------------------------------------------------------
// angle_mod360_iter
// Iterative remainder-by-360 engine: restoring shifted subtraction, one step
// per cycle, from 360<<(STEPS-1) down to 360<<0.
//
// Ports:
//   clk          clock
//   reset_n      synchronous active-low reset
//   start_i      load operand_i and begin STEPS iterations
//   operand_i    unsigned value to reduce (ANGLE_W bits)
//   done_o       high during the final (k = 0) iteration cycle; remainder_o
//                holds the reduced value from the following cycle on
//   remainder_o  reduced value, 0..359 once the iterations complete
// -----------------------------------------------------------------------------
module angle_mod360_iter
    import angle_quadrant_reducer_pkg::*;
#(
    parameter int ANGLE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [ANGLE_W-1:0] operand_i,
    output logic               done_o,
    output logic [8:0]         remainder_o
);

    localparam int STEPS = ANGLE_W - 8;
    localparam int K_W   = $clog2(STEPS);

    // 360 widened to ANGLE_W+1 bits so the largest shift never overflows.
    localparam logic [ANGLE_W:0] FULL_EXT = {{(ANGLE_W - 8){1'b0}}, DEG_FULL_TURN};

    logic [ANGLE_W-1:0] rem_q;
    logic [ANGLE_W-1:0] rem_d;
    logic [K_W-1:0]     k_q;
    logic               busy_q;

    logic [ANGLE_W:0]   shifted_s;
    logic [ANGLE_W:0]   rem_ext_s;
    logic [ANGLE_W:0]   diff_s;

    // One restoring-subtract step against 360 << k.
    always_comb begin
        shifted_s = FULL_EXT << k_q;
        rem_ext_s = {1'b0, rem_q};
        diff_s    = rem_ext_s - shifted_s;
        if (rem_ext_s >= shifted_s) begin
            rem_d = diff_s[ANGLE_W-1:0];
        end else begin
            rem_d = rem_q;
        end
    end

    // Remainder register, step counter and busy flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q  <= {ANGLE_W{1'b0}};
            k_q    <= {K_W{1'b0}};
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= operand_i;
            k_q    <= K_W'(STEPS - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            if (k_q == {K_W{1'b0}}) begin
                busy_q <= 1'b0;
            end else begin
                k_q <= k_q - K_W'(1);
            end
        end else begin
            rem_q  <= rem_q;
            k_q    <= k_q;
            busy_q <= busy_q;
        end
    end

    assign done_o      = busy_q && (k_q == {K_W{1'b0}});
    assign remainder_o = rem_q[8:0];

endmodule

// File: rtl/angle_quadrant_reducer.sv
// -----------------------------------------------------------------------------
// angle_quadrant_reducer
// Converts a raw integer angle in degrees into a quadrant code and a 0..90
// reference angle for the downstream trig LUT stages. One angle in flight at a
// time: IDLE -> REDUCE (STEPS cycles) -> FOLD (1 cycle) -> DONE.
//
// Optional build macro: ANGLE_REDUCE_SIGNED_EN -- treat angle_in as two's
// complement (magnitude is reduced, negative results are mirrored in FOLD).
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   in_valid       angle_in valid
//   in_ready       idle, can accept an angle
//   angle_in       angle in degrees (ANGLE_W bits)
//   out_valid      quadrant/ref_angle valid
//   out_ready      downstream accepts the result
//   quadrant       0..3 for 0..89, 90..179, 180..269, 270..359
//   ref_angle      reference angle 0..90, zero-extended to `DATA_WIDTH
//   en_lut         out_valid && out_ready
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module angle_quadrant_reducer
    import angle_quadrant_reducer_pkg::*;
#(
    parameter int ANGLE_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ANGLE_W-1:0]     angle_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             quadrant,
    output logic [`DATA_WIDTH-1:0] ref_angle,
    output logic                   en_lut
);

    aqr_state_e              state_q;
    logic                    out_valid_q;
    logic [1:0]              quadrant_q;
    logic [`DATA_WIDTH-1:0]  ref_angle_q;

    logic                    start_s;
    logic [ANGLE_W-1:0]      operand_s;
    logic                    iter_done_s;
    logic [8:0]              rem_s;
    logic [8:0]              fold_in_s;
    fold_result_t            fold_s;

`ifdef ANGLE_REDUCE_SIGNED_EN
    logic                    sign_q;

    // Magnitude of the signed input; the most negative value maps to
    // 2^(ANGLE_W-1), which still fits as an unsigned ANGLE_W-bit number.
    always_comb begin
        if (angle_in[ANGLE_W-1]) begin
            operand_s = (~angle_in) + {{(ANGLE_W - 1){1'b0}}, 1'b1};
        end else begin
            operand_s = angle_in;
        end
    end

    // Negative angles land at 360 - |a| mod 360, except exact multiples of 360.
    always_comb begin
        if (sign_q && (rem_s != 9'd0)) begin
            fold_in_s = DEG_FULL_TURN - rem_s;
        end else begin
            fold_in_s = rem_s;
        end
    end

    // Sign flag captured alongside the operand.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
        end else if (start_s) begin
            sign_q <= angle_in[ANGLE_W-1];
        end else begin
            sign_q <= sign_q;
        end
    end
`else
    assign operand_s = angle_in;
    assign fold_in_s = rem_s;
`endif

    assign start_s = (state_q == ST_IDLE) && in_valid;
    assign fold_s  = fold_quadrant(fold_in_s);

    angle_mod360_iter #(
        .ANGLE_W (ANGLE_W)
    ) u_mod360 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_s),
        .operand_i   (operand_s),
        .done_o      (iter_done_s),
        .remainder_o (rem_s)
    );

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            quadrant_q  <= 2'd0;
            ref_angle_q <= {`DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_REDUCE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REDUCE: begin
                    if (iter_done_s) begin
                        state_q <= ST_FOLD;
                    end else begin
                        state_q <= ST_REDUCE;
                    end
                end
                ST_FOLD: begin
                    quadrant_q  <= fold_s.quad;
                    ref_angle_q <= {{(`DATA_WIDTH - 7){1'b0}}, fold_s.ref_angle};
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign quadrant  = quadrant_q;
    assign ref_angle = ref_angle_q;
    assign en_lut    = out_valid_q && out_ready;

endmodule

// File: tb/tb_angle_quadrant_reducer.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_angle_quadrant_reducer;

    localparam int AW    = 16;
    localparam int DW    = `DATA_WIDTH;
    localparam int LAT   = (AW - 8) + 2;
    localparam int BOUND = 40;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] angle_in;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    quadrant;
    logic [DW-1:0] ref_angle;
    logic          en_lut;

    int n_checks = 0;
    int n_errors = 0;

    angle_quadrant_reducer #(.ANGLE_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quadrant  (quadrant),
        .ref_angle (ref_angle),
        .en_lut    (en_lut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] angle;
        int            q;
        int            r;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: true modulo with plain integer arithmetic, then distance
    // to the nearest horizontal axis.
    task automatic model(input logic [AW-1:0] a, output int q, output int r);
        int v;
        int m;
        int off;
`ifdef ANGLE_REDUCE_SIGNED_EN
        v = int'($signed(a));
`else
        v = int'(a);
`endif
        m = v % 360;
        if (m < 0) m += 360;
        q   = m / 90;
        off = m - 90 * q;
        r   = (q % 2 == 1) ? 90 - off : off;
    endtask

    // Issue one angle (caller is at a negedge with in_ready high), wait for out_valid.
    task automatic do_op(input logic [AW-1:0] a, output int lat, output int q,
                         output int r, output int en);
        angle_in = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout angle=%0d: out_valid never rose within %0d cycles", a, BOUND);
        end
        q  = int'(quadrant);
        r  = int'(ref_angle);
        en = int'(en_lut);
    endtask

    int lat, q, r, en, eq, er, hold_q, hold_r, seen;
    logic [AW-1:0] a;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        angle_in  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quadrant", int'(quadrant), 0);
        check("rst_ref", int'(ref_angle), 0);
        check("rst_en_lut", int'(en_lut), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_en_lut", int'(en_lut), 0);

`ifdef ANGLE_REDUCE_SIGNED_EN
        vecs.push_back('{16'hFFE2, 3, 30});   // -30
        vecs.push_back('{16'hFE98, 0, 0});    // -360
        vecs.push_back('{16'h8000, 3, 8});    // -32768
        vecs.push_back('{16'd400, 0, 40});
        vecs.push_back('{16'd90, 1, 90});
        vecs.push_back('{16'd270, 3, 90});
        vecs.push_back('{16'hFFFF, 3, 1});    // -1
`else
        vecs.push_back('{16'd400, 0, 40});
        vecs.push_back('{16'd0, 0, 0});
        vecs.push_back('{16'd89, 0, 89});
        vecs.push_back('{16'd90, 1, 90});
        vecs.push_back('{16'd135, 1, 45});
        vecs.push_back('{16'd180, 2, 0});
        vecs.push_back('{16'd269, 2, 89});
        vecs.push_back('{16'd270, 3, 90});
        vecs.push_back('{16'd359, 3, 1});
        vecs.push_back('{16'd360, 0, 0});
        vecs.push_back('{16'd720, 0, 0});
        vecs.push_back('{16'd65535, 0, 15});
        vecs.push_back('{16'd46080, 0, 0});
`endif

        // Directed table with latency and single-cycle handshake checks
        foreach (vecs[i]) begin
            do_op(vecs[i].angle, lat, q, r, en);
            check($sformatf("tbl_lat[%0d]", vecs[i].angle), lat, LAT);
            check($sformatf("tbl_q[%0d]", vecs[i].angle), q, vecs[i].q);
            check($sformatf("tbl_ref[%0d]", vecs[i].angle), r, vecs[i].r);
            check($sformatf("tbl_en[%0d]", vecs[i].angle), en, 1);
            @(negedge clk);
            check("tbl_valid_drop", int'(out_valid), 0);
            check("tbl_ready_back", int'(in_ready), 1);
        end

        // Back-to-back sweep 0..719 against the model
        for (int i = 0; i < 720; i++) begin
            a = AW'(i);
            model(a, eq, er);
            do_op(a, lat, q, r, en);
            check($sformatf("sweep_q[%0d]", i), q, eq);
            check($sformatf("sweep_ref[%0d]", i), r, er);
            @(negedge clk);
        end

        // Random angles over the full input range
        for (int i = 0; i < 80; i++) begin
            a = AW'($urandom_range(0, (1 << AW) - 1));
            model(a, eq, er);
            do_op(a, lat, q, r, en);
            check($sformatf("rand_lat[%0d]", a), lat, LAT);
            check($sformatf("rand_q[%0d]", a), q, eq);
            check($sformatf("rand_ref[%0d]", a), r, er);
            @(negedge clk);
        end

        // Backpressure: hold out_ready low, poke in_valid, then release
        out_ready = 1'b0;
        do_op(16'd500, lat, q, r, en);
        check("bp_lat", lat, LAT);
        check("bp_q", q, 1);
        check("bp_ref", r, 40);
        check("bp_en_low", en, 0);
        hold_q = q;
        hold_r = r;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                angle_in = 16'd7;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_valid_hold", int'(out_valid), 1);
            check("bp_q_hold", int'(quadrant), hold_q);
            check("bp_ref_hold", int'(ref_angle), hold_r);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_en_hold", int'(en_lut), 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_en_pulse", int'(en_lut), 1);
        @(negedge clk);
        check("bp_valid_drop", int'(out_valid), 0);
        check("bp_ready_back", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || en_lut) seen++;
        end
        check("bp_ignored_input", seen, 0);

        // Reset four cycles into an operation aborts it
        angle_in = 16'd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        do_op(16'd200, lat, q, r, en);
        check("abort_next_lat", lat, LAT);
        check("abort_next_q", q, 2);
        check("abort_next_ref", r, 20);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/angle_quadrant_reducer.md
Name: angle_quadrant_reducer

Overview:
- Front-end stage that converts a raw integer angle in degrees into a quadrant code and a reference angle in 0..90.
- Sits directly upstream of the secant, cosecant and other trig LUT stages, and drives their quadrant, data_in and enable inputs.
- Multi-cycle remainder-by-360 engine with valid/ready handshakes on both sides.
- Accepts one angle at a time; no overlap between operations.

Parameters:
- ANGLE_W, 16, width of angle_in. Legal range is ≥10.
- STEPS, ANGLE_W-8, derived localparam: number of shifted-subtract iterations.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  angle_in is valid.
- in_ready  out  1  block is idle and can accept an angle.
- angle_in  in  ANGLE_W  angle in degrees; unsigned unless the optional feature is enabled.
- out_valid  out  1  quadrant and ref_angle are valid.
- out_ready  in  1  downstream accepts the result.
- quadrant  out  2  quadrant code: 0 = 0..89, 1 = 90..179, 2 = 180..269, 3 = 270..359.
- ref_angle  out  `DATA_WIDTH  reference angle 0..90, zero-extended.
- en_lut  out  1  LUT enable; equals out_valid && out_ready (combinational).

Behaviour:
- Clock and reset: clk, reset_n synchronous active-low.
- Reset values:
  - state = IDLE
  - in_ready = 1 (IDLE)
  - out_valid = 0
  - quadrant = 0
  - ref_angle = 0
  - remainder register = 0
  - step counter = 0
  - Reset asserted mid-operation aborts the operation and discards the result; no out_valid follows.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On in_valid: latch angle_in into rem, set k = STEPS-1, go to REDUCE.
  - REDUCE:
    - One iteration per cycle: if rem ≥ (360 << k) then rem -= (360 << k).
    - Decrement k.
    - After the k = 0 iteration, go to FOLD. This state lasts exactly STEPS cycles.
    - Compare and subtract use ANGLE_W+1-bit arithmetic, so 360 << (STEPS-1) never overflows.
  - FOLD (one cycle; rem is now 0..359). Compute quadrant and ref_angle:
    - q0: ref = rem.
    - q1: ref = 180 - rem.
    - q2: ref = rem - 180.
    - q3: ref = 360 - rem.
    - Register both outputs, set out_valid = 1, go to DONE.
  - DONE:
    - out_valid = 1; outputs held stable while out_ready = 0.
    - On out_ready: out_valid = 0 next cycle, go to IDLE.
- Latency: handshake in cycle N → out_valid first high in cycle N+STEPS+2 (N+10 at default).
- Throughput: one result per STEPS+3 cycles, or more under backpressure.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored.
- Boundaries:
  - 90 → q1, ref 90.
  - 180 → q2, ref 0.
  - 270 → q3, ref 90.
  - 0 → q0, ref 0.
  - 360·m maps to q0, ref 0.
  - Maximum input (2^ANGLE_W − 1) must reduce correctly.

Optional Feature:
- Macro: ANGLE_REDUCE_SIGNED_EN.
- Defined:
  - angle_in is two's complement.
  - IDLE latches |angle_in| plus a sign flag; the most negative value maps to magnitude 2^(ANGLE_W-1), which is representable.
  - FOLD first applies: if sign && rem != 0, then rem = 360 - rem. Quadrant mapping follows.
  - Latency is unchanged.
- Undefined: angle_in is unsigned; no sign logic is present.

Decomposition:
- Shared defines file gains:
  - DEG_FULL_TURN (360), DEG_HALF_TURN (180), DEG_RIGHT (90).
  - Quadrant codes QUAD_I..QUAD_IV (0..3).
  - FSM state encodings for this block.
  - `DATA_WIDTH is reused as-is.
- One natural sub-module: angle_mod360_iter.
  - Holds the REDUCE datapath: rem register, k counter and shifted comparator.
  - Interface: start, done, operand, remainder.
- The top level keeps the FSM, FOLD logic and the handshakes.

Test Plan:
- Reset then idle: reset_n = 0 for 2 cycles → in_ready = 1, out_valid = 0, quadrant = 0, ref_angle = 0; en_lut stays 0.
- 400, out_ready = 1 → after exactly 10 cycles out_valid = 1, q = 0, ref = 40, en_lut = 1 for one cycle, in_ready = 1 the following cycle.
- Sweep 0..719 back-to-back: compare against a model for all values, in particular:
  - 89 → q0/89
  - 90 → q1/90
  - 135 → q1/45
  - 180 → q2/0
  - 269 → q2/89
  - 270 → q3/90
  - 359 → q3/1
  - 360 → q0/0
- 65535 → q0, ref 15. Also 46080 → q0, ref 0 (exercises the top shifted subtract).
- Backpressure: out_ready held 0 for 5 cycles → outputs stable, in_ready = 0, a second in_valid is ignored; releasing out_ready gives a single en_lut pulse.
- Reset at cycle N+4 of an operation → no out_valid; the next angle 200 yields q2/20 with normal latency.
- With ANGLE_REDUCE_SIGNED_EN defined:
  - −30 → q3/30
  - −360 → q0/0
  - −32768 → 32768 mod 360 = 8, then 360 − 8 = 352 → q3/8
